// File: rtl/serial_mem_slave.sv
// Serial memory slave: receives a bit-serial address, mode and write data from the
// serial bus master, and returns read data bit-serially. Both directions are LSB first.
// A local word-addressed memory allows loopback tests without external RAM.
// Optional build macro SERIAL_SLAVE_TIMEOUT_EN adds a stall timeout in ADDR/WDATA.

module serial_mem_slave #(
   parameter int unsigned SLAVE_MEM_ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH           = 8,
   parameter int unsigned MEM_SIZE             = 4096,
   parameter int unsigned READ_LATENCY         = 2,
   parameter int unsigned TIMEOUT_CYCLES       = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic swdata,
   input  logic smode,
   input  logic mvalid,
   output logic srdata,
   output logic svalid,
   output logic sready
);

   localparam int unsigned AW     = SLAVE_MEM_ADDR_WIDTH;
   localparam int unsigned DW     = DATA_WIDTH;
   localparam int unsigned MaxAd  = (AW > DW) ? AW : DW;
   localparam int unsigned MaxCnt = (MaxAd > READ_LATENCY) ? MaxAd : READ_LATENCY;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);
   localparam int unsigned MemAw  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   localparam logic [CntW-1:0] AddrLast = CntW'(AW - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(DW - 1);
   localparam logic [CntW-1:0] LatLast  = CntW'(READ_LATENCY);

   // Reject parameter sets the datapath cannot honour.
   if (READ_LATENCY < 1 || TIMEOUT_CYCLES < 1 || AW < 1 || DW < 1 || MEM_SIZE < 1 ||
       MEM_SIZE > (64'd1 << AW)) begin : gen_bad_params
      $error("serial_mem_slave: illegal parameter combination");
   end

   typedef enum logic [2:0] {StIdle, StAddr, StWdata, StWrite, StRlat, StRdata} state_e;

   state_e          state;
   logic            mode;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rbuf;
   logic [CntW-1:0] cnt;
   logic [DW-1:0]   mem [MEM_SIZE];
   logic [DW-1:0]   rd_word;
   logic            addr_ok;
   logic [MemAw-1:0] mem_idx;

`ifdef SERIAL_SLAVE_TIMEOUT_EN
   localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [StallW-1:0] StallLast = StallW'(TIMEOUT_CYCLES - 1);
   logic [StallW-1:0] stall;
`endif

   // Out-of-range addresses read as zero and never reach the array.
   always_comb begin
      addr_ok = 32'(addr) < MEM_SIZE;
      mem_idx = addr[MemAw-1:0];
      rd_word = addr_ok ? mem[mem_idx] : '0;
   end

   // Memory array: no reset, contents survive rstn.
   always_ff @(posedge clk) begin
      if (state == StWrite && addr_ok) begin
         mem[mem_idx] <= wdata;
      end
   end

   // Transaction FSM with registered serial outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= StIdle;
         mode   <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         rbuf   <= '0;
         cnt    <= '0;
         srdata <= 1'b0;
         svalid <= 1'b0;
         sready <= 1'b1;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
         stall  <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (mvalid) begin
                  mode    <= smode;
                  addr[0] <= swdata;
                  sready  <= 1'b0;
                  if (AddrLast == '0) begin
                     cnt   <= '0;
                     state <= smode ? StWdata : StRlat;
                  end else begin
                     cnt   <= CntW'(1);
                     state <= StAddr;
                  end
               end
            end
            StAddr: begin
               if (mvalid) begin
                  addr[cnt] <= swdata;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
                  stall <= '0;
`endif
                  if (cnt == AddrLast) begin
                     cnt   <= '0;
                     state <= mode ? StWdata : StRlat;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef SERIAL_SLAVE_TIMEOUT_EN
               else if (stall == StallLast) begin
                  stall  <= '0;
                  cnt    <= '0;
                  sready <= 1'b1;
                  state  <= StIdle;
               end else begin
                  stall <= stall + 1'b1;
               end
`endif
            end
            StWdata: begin
               if (mvalid) begin
                  wdata[cnt] <= swdata;
`ifdef SERIAL_SLAVE_TIMEOUT_EN
                  stall <= '0;
`endif
                  if (cnt == DataLast) begin
                     cnt   <= '0;
                     state <= StWrite;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef SERIAL_SLAVE_TIMEOUT_EN
               else if (stall == StallLast) begin
                  stall  <= '0;
                  cnt    <= '0;
                  sready <= 1'b1;
                  state  <= StIdle;
               end else begin
                  stall <= stall + 1'b1;
               end
`endif
            end
            StWrite: begin
               sready <= 1'b1;
               state  <= StIdle;
            end
            StRlat: begin
               // Word is captured on the first latency cycle; bit 0 leaves on the last.
               if (cnt == '0) begin
                  rbuf <= rd_word;
               end
               if (cnt == LatLast) begin
                  cnt    <= '0;
                  svalid <= 1'b1;
                  srdata <= rbuf[0];
                  rbuf   <= rbuf >> 1;
                  state  <= StRdata;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StRdata: begin
               if (cnt == DataLast) begin
                  cnt    <= '0;
                  svalid <= 1'b0;
                  srdata <= 1'b0;
                  sready <= 1'b1;
                  state  <= StIdle;
               end else begin
                  cnt    <= cnt + 1'b1;
                  srdata <= rbuf[0];
                  rbuf   <= rbuf >> 1;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mem_slave.sv
// Directed bench for serial_mem_slave: a full-size instance and a MEM_SIZE = 3072
// instance share the same stimulus so out-of-range behaviour can be compared.

module tb_serial_mem_slave;

   localparam int RL = 2;

   logic clk = 1'b0;
   logic rstn;
   logic swdata;
   logic smode;
   logic mvalid;
   logic srdata, svalid, sready;
   logic srdata_s, svalid_s, sready_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_mem_slave dut (
      .clk    (clk),
      .rstn   (rstn),
      .swdata (swdata),
      .smode  (smode),
      .mvalid (mvalid),
      .srdata (srdata),
      .svalid (svalid),
      .sready (sready)
   );

   serial_mem_slave #(
      .MEM_SIZE (3072)
   ) dut_small (
      .clk    (clk),
      .rstn   (rstn),
      .swdata (swdata),
      .smode  (smode),
      .mvalid (mvalid),
      .srdata (srdata_s),
      .svalid (svalid_s),
      .sready (sready_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Address bits go out LSB first; smode is inverted after bit 0 to show it is ignored.
   task automatic send_addr(input logic mode, input logic [11:0] a, input int stall_at,
                            input int nstall);
      for (int i = 0; i < 12; i++) begin
         smode  = (i == 0) ? mode : ~mode;
         swdata = a[i];
         mvalid = 1'b1;
         @(posedge clk); #1;
         if (i == stall_at) begin
            mvalid = 1'b0;
            swdata = ~swdata;
            repeat (nstall) @(posedge clk);
            #1;
         end
      end
      mvalid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] d, input int nbits, input int stall_at,
                            input int nstall);
      for (int i = 0; i < nbits; i++) begin
         swdata = d[i];
         mvalid = 1'b1;
         @(posedge clk); #1;
         if (i == stall_at) begin
            mvalid = 1'b0;
            swdata = ~swdata;
            repeat (nstall) @(posedge clk);
            #1;
         end
      end
      mvalid = 1'b0;
   endtask

   task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int sa,
                           input int sd);
      send_addr(1'b1, a, sa, 3);
      send_data(d, 8, sd, 3);
      @(negedge clk);
      check("write_cycle_sready", 32'(sready), 32'd0);
      @(negedge clk);
      check("after_write_sready", 32'(sready), 32'd1);
   endtask

   task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input logic [7:0] exp_s,
                          input bit toggle);
      logic [7:0] word, word_s;
      word   = '0;
      word_s = '0;
      send_addr(1'b0, a, -1, 0);
      for (int k = 0; k <= RL; k++) begin
         @(negedge clk);
         check("rlat_svalid", 32'(svalid), 32'd0);
         check("rlat_sready", 32'(sready), 32'd0);
         if (toggle) begin
            mvalid = 1'($urandom_range(0, 1));
            swdata = 1'($urandom_range(0, 1));
            smode  = 1'($urandom_range(0, 1));
         end
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("rdata_svalid", 32'(svalid), 32'd1);
         check("rdata_sready", 32'(sready), 32'd0);
         check("rdata_svalid_small", 32'(svalid_s), 32'd1);
         word[j]   = srdata;
         word_s[j] = srdata_s;
         if (toggle && j < 7) begin
            mvalid = 1'($urandom_range(0, 1));
            swdata = 1'($urandom_range(0, 1));
            smode  = 1'($urandom_range(0, 1));
         end else begin
            mvalid = 1'b0;
         end
      end
      @(negedge clk);
      check("read_end_svalid", 32'(svalid), 32'd0);
      check("read_end_sready", 32'(sready), 32'd1);
      check("read_word", 32'(word), 32'(exp));
      check("read_word_small", 32'(word_s), 32'(exp_s));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn   = 1'b0;
      swdata = 1'b0;
      smode  = 1'b0;
      mvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("reset_srdata", 32'(srdata), 32'd0);
      check("reset_svalid", 32'(svalid), 32'd0);
      check("reset_sready", 32'(sready), 32'd1);
      check("reset_sready_small", 32'(sready_s), 32'd1);

      // Basic write then back-to-back read: bits 1,0,1,0,0,1,0,1.
      do_write(12'h123, 8'hA5, -1, -1);
      do_read(12'h123, 8'hA5, 8'hA5, 1'b0);

      // Stalls after address bit 5 and data bit 2.
      do_write(12'h0FF, 8'h3C, 5, 2);
      do_read(12'h0FF, 8'h3C, 8'h3C, 1'b0);

      // 0xC00 is out of range only for the 3072-word instance; it must not alias 0x000.
      do_write(12'h000, 8'h5A, -1, -1);
      do_write(12'hC00, 8'h77, -1, -1);
      do_read(12'hC00, 8'h77, 8'h00, 1'b0);
      do_read(12'h000, 8'h5A, 8'h5A, 1'b0);

      // Reset in the middle of write data aborts without a memory write.
      do_write(12'h010, 8'h11, -1, -1);
      send_addr(1'b1, 12'h010, -1, 0);
      send_data(8'hEE, 4, -1, 0);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("abort_sready", 32'(sready), 32'd1);
      check("abort_svalid", 32'(svalid), 32'd0);
      do_read(12'h010, 8'h11, 8'h11, 1'b0);

      // Bus activity during RLAT/RDATA is ignored.
      do_read(12'h123, 8'hA5, 8'hA5, 1'b1);

`ifdef SERIAL_SLAVE_TIMEOUT_EN
      // Three address bits, then a 16-cycle stall triggers the timeout.
      for (int i = 0; i < 3; i++) begin
         smode  = (i == 0);
         swdata = 1'b1;
         mvalid = 1'b1;
         @(posedge clk); #1;
      end
      mvalid = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("timeout_pre_sready", 32'(sready), 32'd0);
      @(negedge clk);
      check("timeout_sready", 32'(sready), 32'd1);
      do_write(12'h200, 8'h42, -1, -1);
      do_read(12'h200, 8'h42, 8'h42, 1'b0);
      do_read(12'h123, 8'hA5, 8'hA5, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
